// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into CPU memory,
// checks an additive checksum and releases the CPU from reset once the image is good.
module program_loader #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DataWidth-1:0] RxData,
    input  logic                 RxValid,
    output logic                 RxReady,
    input  logic                 Reload,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic [DataWidth-1:0] Mem_DOut,
    output logic                 Mem_Wr,
    output logic                 Mem_En,
    output logic                 CPU_Reset,
    output logic                 Done,
    output logic                 Error
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [AddrWidth:0]   CountOne = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};
    // A length byte of zero stands for a full 2^AddrWidth-byte image.
    localparam logic [AddrWidth:0]   FullLen  = {1'b1, {AddrWidth{1'b0}}};

    state_t               r_state;
    logic [AddrWidth:0]   r_count;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_sum;

    logic                 w_xfer;
    logic [AddrWidth:0]   w_len;

    assign RxReady = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_SUM);
    assign w_xfer  = RxValid && RxReady;
    assign w_len   = (RxData == '0) ? FullLen : (AddrWidth+1)'(RxData);

    // NOTE: every register here is assigned with <= so all of them update together
    // on the edge; a blocking = would let later statements see half-updated state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_LEN;
            r_count   <= '0;
            r_addr    <= '0;
            r_sum     <= '0;
            Mem_Addr  <= '0;
            Mem_DOut  <= '0;
            Mem_Wr    <= 1'b0;
            Mem_En    <= 1'b0;
            CPU_Reset <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Mem_Wr <= 1'b0;
            Mem_En <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_xfer) begin
                        r_count <= w_len;
                        r_addr  <= '0;
                        r_sum   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        Mem_Addr <= r_addr;
                        Mem_DOut <= RxData;
                        Mem_Wr   <= 1'b1;
                        Mem_En   <= 1'b1;
                        r_addr   <= r_addr + AddrOne;
                        r_sum    <= r_sum + RxData;
                        r_count  <= r_count - CountOne;
                        if (r_count == CountOne) begin
                            r_state <= S_SUM;
                        end
                    end
                end
                S_SUM: begin
                    if (w_xfer) begin
                        if (RxData == r_sum) begin
                            r_state   <= S_DONE;
                            Done      <= 1'b1;
                            CPU_Reset <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            Error   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (Reload) begin
                        r_state   <= S_LEN;
                        Done      <= 1'b0;
                        Error     <= 1'b0;
                        CPU_Reset <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads, hand-written corner
// sequences and randomized loads checked against a stream-level reference model.
module tb_program_loader;

    logic       Clk;
    logic       Reset;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;
    logic       Reload;
    logic [7:0] Mem_Addr;
    logic [7:0] Mem_DOut;
    logic       Mem_Wr;
    logic       Mem_En;
    logic       CPU_Reset;
    logic       Done;
    logic       Error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];
    int         wr_count = 0;

    typedef struct {
        int         n;
        logic [7:0] b [6];
        int         mode;
        bit         exp_done;
        bit         exp_err;
        int         exp_wr;
    } vec_t;

    program_loader #(
        .DataWidth(8),
        .AddrWidth(8)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .RxReady  (RxReady),
        .Reload   (Reload),
        .Mem_Addr (Mem_Addr),
        .Mem_DOut (Mem_DOut),
        .Mem_Wr   (Mem_Wr),
        .Mem_En   (Mem_En),
        .CPU_Reset(CPU_Reset),
        .Done     (Done),
        .Error    (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behaves as the CPU memory: captures a write on the edge that ends the write cycle.
    always @(posedge Clk) begin
        if (Mem_Wr && Mem_En) begin
            mem[Mem_Addr] <= Mem_DOut;
            wr_count      <= wr_count + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Streams one image and checks it against expectations computed from the stream:
    // byte 0 is the length (0 = 256), then the payload, then the modulo-256 sum.
    // mode 0: back-to-back, 1: one idle cycle between bytes, 2: 0..2 random idle cycles.
    task automatic play(input logic [7:0] s[$], input int mode, input bit noise,
                        input string tag, output bit got_done, output bit got_err,
                        output int got_wr);
        int         len;
        int         base;
        int         idle;
        logic [7:0] sum;
        bit         ok;
        len = (s[0] == 8'd0) ? 256 : int'(s[0]);
        sum = 8'd0;
        for (int i = 1; i <= len; i++) sum = sum + s[i];
        ok   = (s[len+1] == sum);
        base = wr_count;
        @(negedge Clk);
        for (int i = 0; i < s.size(); i++) begin
            check({tag, ":rx_ready_loading"}, RxReady, 1);
            check({tag, ":cpu_reset_held"}, CPU_Reset, 1);
            RxData  = s[i];
            RxValid = 1'b1;
            @(posedge Clk);
            @(negedge Clk);
            RxValid = 1'b0;
            if (i >= 1 && i <= len) begin
                check({tag, ":wr_pulse"}, Mem_Wr, 1);
                check({tag, ":en_pulse"}, Mem_En, 1);
                check({tag, ":wr_addr"}, Mem_Addr, (i - 1) % 256);
                check({tag, ":wr_data"}, Mem_DOut, s[i]);
            end else begin
                check({tag, ":no_wr"}, Mem_Wr, 0);
                check({tag, ":no_en"}, Mem_En, 0);
            end
            idle = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
            if (i == s.size() - 1) idle = 0;
            repeat (idle) begin
                RxData = 8'($urandom);
                Reload = noise && ($urandom_range(0, 1) == 1);
                @(posedge Clk);
                @(negedge Clk);
                Reload = 1'b0;
                check({tag, ":stall_no_wr"}, Mem_Wr, 0);
            end
        end
        check({tag, ":cpu_reset_after_sum"}, CPU_Reset, !ok);
        check({tag, ":done"}, Done, ok);
        check({tag, ":error"}, Error, !ok);
        check({tag, ":rx_ready_final"}, RxReady, 0);
        repeat (2) @(negedge Clk);
        check({tag, ":done_hold"}, Done, ok);
        check({tag, ":idle_no_wr"}, Mem_Wr, 0);
        got_wr = wr_count - base;
        check({tag, ":wr_count"}, got_wr, len);
        for (int j = 0; j < len; j++) check({tag, ":mem"}, mem[j], s[j+1]);
        got_done = Done;
        got_err  = Error;
        Reload = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reload = 1'b0;
        check({tag, ":reload_cpu_reset"}, CPU_Reset, 1);
        check({tag, ":reload_done_clr"}, Done, 0);
        check({tag, ":reload_error_clr"}, Error, 0);
        check({tag, ":reload_rx_ready"}, RxReady, 1);
    endtask

    initial begin
        vec_t       vecs [5];
        logic [7:0] q [$];
        bit         d;
        bit         e;
        int         w;
        int         base;

        vecs[0] = '{n: 5, b: '{8'h03, 8'h12, 8'h34, 8'h56, 8'h9C, 8'h00}, mode: 0, exp_done: 1, exp_err: 0, exp_wr: 3};
        vecs[1] = '{n: 4, b: '{8'h02, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00}, mode: 0, exp_done: 0, exp_err: 1, exp_wr: 2};
        vecs[2] = '{n: 5, b: '{8'h03, 8'h12, 8'h34, 8'h56, 8'h9C, 8'h00}, mode: 1, exp_done: 1, exp_err: 0, exp_wr: 3};
        vecs[3] = '{n: 3, b: '{8'h01, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00}, mode: 0, exp_done: 1, exp_err: 0, exp_wr: 1};
        vecs[4] = '{n: 3, b: '{8'h01, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00}, mode: 1, exp_done: 0, exp_err: 1, exp_wr: 1};

        Reset   = 1'b1;
        RxData  = 8'h00;
        RxValid = 1'b0;
        Reload  = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset:rx_ready", RxReady, 1);
        check("reset:cpu_reset", CPU_Reset, 1);
        check("reset:done", Done, 0);
        check("reset:error", Error, 0);
        check("reset:mem_wr", Mem_Wr, 0);
        check("reset:mem_en", Mem_En, 0);
        check("reset:mem_addr", Mem_Addr, 0);
        check("reset:mem_dout", Mem_DOut, 0);
        Reset = 1'b0;

        // Entries 2 and 3 also exercise a Reload from DONE into a fresh image.
        for (int t = 0; t < 5; t++) begin
            q = {};
            for (int k = 0; k < vecs[t].n; k++) q.push_back(vecs[t].b[k]);
            play(q, vecs[t].mode, 1'b0, $sformatf("vec%0d", t), d, e, w);
            check($sformatf("vec%0d:tbl_done", t), d, vecs[t].exp_done);
            check($sformatf("vec%0d:tbl_err", t), e, vecs[t].exp_err);
            check($sformatf("vec%0d:tbl_writes", t), w, vecs[t].exp_wr);
        end

        q = {8'h00};
        for (int k = 0; k < 256; k++) q.push_back(8'(k));
        q.push_back(8'h80);
        play(q, 0, 1'b0, "len0", d, e, w);
        check("len0:tbl_done", d, 1);
        check("len0:tbl_writes", w, 256);

        for (int r = 0; r < 24; r++) begin
            int         len;
            logic [7:0] sum;
            logic [7:0] b;
            len = $urandom_range(1, 40);
            sum = 8'd0;
            q   = {8'(len)};
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                q.push_back(b);
                sum = sum + b;
            end
            if ($urandom_range(0, 1) == 1) q.push_back(sum);
            else q.push_back(sum ^ 8'($urandom_range(1, 255)));
            play(q, 2, 1'b1, $sformatf("rand%0d", r), d, e, w);
        end

        // Reset arrives together with the third payload byte of a load.
        base = wr_count;
        @(negedge Clk);
        RxData = 8'h04; RxValid = 1'b1;
        @(posedge Clk); @(negedge Clk);
        RxData = 8'h11;
        @(posedge Clk); @(negedge Clk);
        RxData = 8'h22;
        @(posedge Clk); @(negedge Clk);
        check("rst_mid:second_wr", Mem_Wr, 1);
        check("rst_mid:second_addr", Mem_Addr, 8'h01);
        RxData = 8'h33; Reset = 1'b1; Reload = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0; RxValid = 1'b0; Reload = 1'b0;
        check("rst_mid:no_wr", Mem_Wr, 0);
        check("rst_mid:no_en", Mem_En, 0);
        check("rst_mid:cpu_reset", CPU_Reset, 1);
        check("rst_mid:rx_ready", RxReady, 1);
        check("rst_mid:done", Done, 0);
        check("rst_mid:error", Error, 0);
        check("rst_mid:wr_count", wr_count - base, 2);
        check("rst_mid:mem0_kept", mem[0], 8'h11);
        check("rst_mid:mem1_kept", mem[1], 8'h22);
        q = {8'h01, 8'h55, 8'h55};
        play(q, 0, 1'b0, "rst_mid_next", d, e, w);
        check("rst_mid:next_done", d, 1);
        check("rst_mid:next_writes", w, 1);
        check("rst_mid:mem1_after", mem[1], 8'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter DataWidth, default 8: width of the byte stream, memory data and checksum.
REQ-002 The block SHALL have parameter AddrWidth, default 8: width of the memory address, matching the CPU memory (2^8 = 256 locations).
REQ-003 The block SHALL have port Clk  input  1: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port Reset  input  1: synchronous, active-high reset.
REQ-005 The block SHALL have port RxData  input  DataWidth: incoming stream byte.
REQ-006 The block SHALL have port RxValid  input  1: RxData is valid this cycle.
REQ-007 The block SHALL have port RxReady  output  1: the loader accepts a byte this cycle; a transfer occurs when RxValid and RxReady are both 1.
REQ-008 The block SHALL have port Reload  input  1: a one-cycle request to restart loading from DONE or ERROR.
REQ-009 The block SHALL have port Mem_Addr  output  AddrWidth: memory write address.
REQ-010 The block SHALL have port Mem_DOut  output  DataWidth: memory write data, driving the memory DIn.
REQ-011 The block SHALL have port Mem_Wr  output  1: memory write enable.
REQ-012 The block SHALL have port Mem_En  output  1: memory enable.
REQ-013 The block SHALL have port CPU_Reset  output  1: holds the CPU in reset while 1.
REQ-014 The block SHALL have port Done  output  1: the image loaded and its checksum verified.
REQ-015 The block SHALL have port Error  output  1: checksum mismatch.

Function
REQ-016 States SHALL be LEN, DATA, SUM, DONE and ERROR, with exactly one active at a time.
REQ-017 RxReady SHALL be 1 in LEN, DATA and SUM, and 0 in DONE and ERROR.
REQ-018 In LEN, on a transfer, the remaining count SHALL load with RxData, or 256 when RxData = 0; the count register is AddrWidth+1 bits wide.
REQ-019 On that LEN transfer, the address SHALL clear to 0, the running sum SHALL clear to 0, and the state SHALL move to DATA.
REQ-020 In DATA, on each transfer, the block SHALL register Mem_DOut = RxData and Mem_Addr = the current address, with Mem_Wr = Mem_En = 1 for exactly the next cycle.
REQ-021 Each DATA-state write SHALL therefore occur 1 cycle after its handshake.
REQ-022 In DATA, on each transfer, the address SHALL increment modulo 2^AddrWidth, the sum SHALL update to (sum + RxData) mod 2^DataWidth, and the count SHALL decrement.
REQ-023 The transfer that brings the count to 0 SHALL move the state to SUM.
REQ-024 Mem_Wr and Mem_En SHALL be 0 in every cycle that does not follow a DATA transfer.
REQ-025 Cycles with RxValid = 0 SHALL stall with no state, count, address or sum change.
REQ-026 In SUM, on a transfer, the state SHALL move to DONE if RxData equals the sum, and to ERROR otherwise.
REQ-027 DONE SHALL be entered no earlier than 1 cycle after the final memory write.
REQ-028 CPU_Reset SHALL be 1 in every state except DONE, and SHALL be 0 from the first cycle in DONE.
REQ-029 Done SHALL be 1 only in DONE, and Error SHALL be 1 only in ERROR.
REQ-030 Reload = 1 in DONE or ERROR SHALL move the state to LEN on the next edge and SHALL reassert CPU_Reset in that same cycle.
REQ-031 Reload SHALL be ignored in LEN, DATA and SUM.
REQ-032 All outputs SHALL be registered, except RxReady, which is decoded from the current state.

Reset
REQ-033 While Reset = 1, on an edge, the state SHALL become LEN.
REQ-034 While Reset = 1, on an edge, count, address and sum SHALL clear to 0.
REQ-035 While Reset = 1, on an edge, Mem_Addr, Mem_DOut, Mem_Wr, Mem_En, Done and Error SHALL become 0, and CPU_Reset SHALL become 1.
REQ-036 Reset SHALL take priority over any transfer or Reload in the same cycle.
REQ-037 Reset mid-load SHALL drop any pending write, so that no Mem_Wr pulse occurs in the cycle after the Reset edge.
REQ-038 Memory contents SHALL NOT be altered by Reset.

Verification
REQ-039 The bench SHALL check a nominal load: stream 0x03, 0x12, 0x34, 0x56, 0x9C with RxValid held high -> writes 0x12@0x00, 0x34@0x01, 0x56@0x02; Done = 1; CPU_Reset falls one cycle after the 0x9C handshake.
REQ-040 The bench SHALL check a bad checksum: stream 0x02, 0x01, 0x02, 0x04 -> two writes occur, Error = 1, CPU_Reset stays 1, and RxReady = 0.
REQ-041 The bench SHALL check length 0: stream 0x00, then 256 bytes of value i, then checksum 0x80 -> 256 writes at addresses 0x00..0xFF with no address overflow, and Done = 1.
REQ-042 The bench SHALL check stalls: a nominal load with RxValid toggled 1/0 every cycle -> identical writes, no extra Mem_Wr pulses, and Done = 1.
REQ-043 The bench SHALL check Reload: in DONE, pulse Reload, then stream 0x01, 0xAA, 0xAA -> CPU_Reset = 1 during reload, 0xAA is written @0x00, and Done = 1.
REQ-044 The bench SHALL check reset mid-load: assert Reset after the second DATA handshake -> no write for the in-flight byte, the state is LEN, CPU_Reset = 1, and the next byte is taken as a length.
